// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter with TX FIFO, status/level register, sticky overflow, flush and TX-done irq.
// Optional feature macro: DEBUG_UART_PARITY_EN adds a parity bit per frame (CTRL bit2 = odd select).
module debug_uart_tx_fifo #(
    parameter int unsigned CLOCK_MHZ  = 64,
    parameter int unsigned BIT_RATE   = 4_000_000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        irq_tx_done
);
    localparam int unsigned DIV = (CLOCK_MHZ * 1_000_000) / BIT_RATE;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("debug_uart_tx_fifo: CLOCK_MHZ*1e6/BIT_RATE must be >= 2");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("debug_uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
            $error("debug_uart_tx_fifo: DATA_BITS must be in 5..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef DEBUG_UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   irq_q;
    logic                   irq_en;
    logic                   overflow;
    logic                   bit_end;
    logic                   pop;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   empty, full, push;

    logic                   wr_en, push_req, stat_wr, ctrl_wr, flush;
    logic [31:0]            status, ctrl;

`ifdef DEBUG_UART_PARITY_EN
    logic                   par_q, par_d;
    logic                   par_odd;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, data_read_n, data_in};

    // Register decode
    assign wr_en    = (data_write_n != 2'b11);
    assign push_req = wr_en && (addr_in == 4'h0);
    assign stat_wr  = wr_en && (addr_in == 4'h4);
    assign ctrl_wr  = wr_en && (addr_in == 4'h8);
    assign flush    = ctrl_wr && data_in[1];

    assign empty = (level == '0);
    assign full  = (level == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level <= level + 1'b1;
                else if (pop && !push) level <= level - 1'b1;
            end
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (stat_wr && data_in[2]) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
            par_odd <= 1'b0;
`endif
        end else if (ctrl_wr) begin
            irq_en <= data_in[0];
`ifdef DEBUG_UART_PARITY_EN
            par_odd <= data_in[2];
`endif
        end
    end

    assign bit_end = (cnt_q == CW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef DEBUG_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef DEBUG_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d = mem[rd_ptr];
            idx_d   = '0;
`ifdef DEBUG_UART_PARITY_EN
            par_d   = (^mem[rd_ptr]) ^ par_odd;
`endif
        end

        // Output is registered from the next state so the pin changes on the state edge.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef DEBUG_UART_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            irq_q   <= irq_en && (state_q == ST_IDLE) && empty;
`ifdef DEBUG_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign status = {24'h0, 4'(level), 1'b0, overflow, full, (state_q != ST_IDLE) || !empty};
`ifdef DEBUG_UART_PARITY_EN
    assign ctrl   = {29'h0, par_odd, 1'b0, irq_en};
`else
    assign ctrl   = {31'h0, irq_en};
`endif

    always_comb begin
        case (addr_in)
            4'h0:    data_out = '0;
            4'h4:    data_out = status;
            4'h8:    data_out = ctrl;
            default: data_out = '1;
        endcase
    end

    assign data_ready  = 1'b1;
    assign uart_txd    = txd_q;
    assign irq_tx_done = irq_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed self-checking bench for debug_uart_tx_fifo at default parameters (DIV = 16).
// Honours DEBUG_UART_PARITY_EN to expect the parity bit and CTRL bit2.
module tb_debug_uart_tx_fifo;
    logic        clk;
    logic        rst;
    logic [3:0]  addr_in;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        uart_txd;
    logic        irq_tx_done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef DEBUG_UART_PARITY_EN
    localparam int unsigned NB = 11;
    logic par_odd_sel = 1'b0;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FL = 16 * NB;

    debug_uart_tx_fifo #(
        .CLOCK_MHZ  (64),
        .BIT_RATE   (4_000_000),
        .FIFO_DEPTH (4),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .uart_txd     (uart_txd),
        .irq_tx_done  (irq_tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one write for the next rising edge and returns at the following falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        addr_in      = a;
        data_in      = d;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr_in     = a;
        data_read_n = 2'b00;
        #1;
        check_eq(tag, data_out, exp);
        data_read_n = 2'b11;
    endtask

    // Called at the falling edge just after the start bit begins; returns one frame later.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [15:0] bits;
        bits = {6'b0, 1'b1, b, 1'b0};
`ifdef DEBUG_UART_PARITY_EN
        bits = {5'b0, 1'b1, (^b) ^ par_odd_sel, b, 1'b0};
`endif
        check_eq({tag, "_start_edge"}, 32'(uart_txd), 32'd0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            check_eq($sformatf("%s_bit%0d", tag, i), 32'(uart_txd), 32'(bits[i]));
            if (i != NB - 1) repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        addr_in      = 4'h0;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_irq", 32'(irq_tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        expect_reg("rst_status", 4'h4, 32'h0);
        expect_reg("rst_ctrl", 4'h8, 32'h0);
        expect_reg("txdata_reads0", 4'h0, 32'h0);
        expect_reg("bad_offset", 4'hC, 32'hFFFF_FFFF);
        check_eq("data_ready", 32'(data_ready), 32'd1);
        bus_write(4'hC, 32'hFF);
        expect_reg("bad_offset_wr", 4'h4, 32'h0);

        // Single byte from idle: start bit appears after the edge following the push
        bus_write(4'h0, 32'h55);
        check_eq("55_pre_start", 32'(uart_txd), 32'd1);
        expect_reg("55_status_queued", 4'h4, 32'h11);
        @(negedge clk);
        expect_reg("55_status_sending", 4'h4, 32'h01);
        check_frame(8'h55, "f55");
        expect_reg("55_status_done", 4'h4, 32'h00);
        check_eq("55_idle_txd", 32'(uart_txd), 32'd1);

        // Six back-to-back pushes: one pops, four queue, the sixth overflows
        for (int i = 1; i <= 6; i++) bus_write(4'h0, 32'(i));
        check_eq("burst_f1_started", 32'(uart_txd), 32'd0);
        expect_reg("burst_status", 4'h4, 32'h47);
        bus_write(4'h4, 32'h04);
        expect_reg("ovf_cleared", 4'h4, 32'h43);
        repeat (FL - 5) @(negedge clk);
        for (int i = 2; i <= 5; i++) check_frame(8'(i), $sformatf("burst%0d", i));
        expect_reg("burst_done", 4'h4, 32'h00);
        check_eq("burst_idle_txd", 32'(uart_txd), 32'd1);

        // TX-done interrupt
        bus_write(4'h8, 32'h1);
        check_eq("irq_en_lag", 32'(irq_tx_done), 32'd0);
        @(negedge clk);
        check_eq("irq_idle", 32'(irq_tx_done), 32'd1);
        bus_write(4'h0, 32'hA3);
        check_eq("irq_push_edge", 32'(irq_tx_done), 32'd1);
        @(negedge clk);
        check_eq("irq_busy", 32'(irq_tx_done), 32'd0);
        check_frame(8'hA3, "fA3");
        check_eq("irq_at_stop_end", 32'(irq_tx_done), 32'd0);
        @(negedge clk);
        check_eq("irq_after_stop", 32'(irq_tx_done), 32'd1);
        bus_write(4'h8, 32'h0);
        @(negedge clk);
        check_eq("irq_disabled", 32'(irq_tx_done), 32'd0);

        // Flush mid-frame: current frame finishes, queued bytes are discarded
        bus_write(4'h0, 32'h3C);
        for (int i = 0; i < 4; i++) bus_write(4'h0, 32'h11 + 32'(i));
        expect_reg("flush_prefill", 4'h4, 32'h43);
        bus_write(4'h8, 32'h2);
        expect_reg("flush_level0", 4'h4, 32'h01);
        expect_reg("flush_ctrl_rd", 4'h8, 32'h0);
        repeat (FL - 5) @(negedge clk);
        check_eq("flush_stop_txd", 32'(uart_txd), 32'd1);
        @(negedge clk);
        expect_reg("flush_done", 4'h4, 32'h00);
        repeat (40) @(negedge clk);
        check_eq("flush_txd_high", 32'(uart_txd), 32'd1);

        // Parity option
`ifdef DEBUG_UART_PARITY_EN
        bus_write(4'h0, 32'h07);
        @(negedge clk);
        check_frame(8'h07, "par_even");
        bus_write(4'h8, 32'h4);
        expect_reg("par_ctrl_rd", 4'h8, 32'h4);
        par_odd_sel = 1'b1;
        bus_write(4'h0, 32'h07);
        @(negedge clk);
        check_frame(8'h07, "par_odd");
        bus_write(4'h8, 32'h0);
`else
        bus_write(4'h8, 32'h4);
        expect_reg("ctrl_bit2_ignored", 4'h8, 32'h0);
`endif

        // Asynchronous reset in the middle of a frame
        bus_write(4'h8, 32'h1);
        bus_write(4'h0, 32'h00);
        repeat (20) @(negedge clk);
        check_eq("prerst_txd", 32'(uart_txd), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("async_rst_txd", 32'(uart_txd), 32'd1);
        check_eq("async_rst_irq", 32'(irq_tx_done), 32'd0);
        expect_reg("async_rst_status", 4'h4, 32'h00);
        expect_reg("async_rst_ctrl", 4'h8, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("postrst_txd", 32'(uart_txd), 32'd1);
        expect_reg("postrst_status", 4'h4, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
